// File: rtl/max_tree_pkg.sv
// max_tree_pkg: shared helpers and constants for the segmented max/argmax tree
package max_tree_pkg;
  localparam int unsigned MAX_NODE_W = 256;
  localparam logic [MAX_NODE_W-1:0] SLOT_ZERO = '0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/max_idx_node.sv
// max_idx_node: registered two-input signed max with valid/index propagation, A wins ties
module max_idx_node
  import max_tree_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX_W = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_a_v,
  input  logic signed [DATA_W-1:0] i_a_val,
  input  logic [IDX_W-1:0]         i_a_idx,
  input  logic                     i_b_v,
  input  logic signed [DATA_W-1:0] i_b_val,
  input  logic [IDX_W-1:0]         i_b_idx,
  output logic                     o_v,
  output logic signed [DATA_W-1:0] o_val,
  output logic [IDX_W-1:0]         o_idx
);
  typedef struct packed {
    logic                     v;
    logic signed [DATA_W-1:0] val;
    logic [IDX_W-1:0]         idx;
  } node_t;
  localparam int NW = 1 + DATA_W + IDX_W;
  node_t a, b, r_d, r_q;
  logic take_a;
  assign a = '{v: i_a_v, val: i_a_val, idx: i_a_idx};
  assign b = '{v: i_b_v, val: i_b_val, idx: i_b_idx};
  assign take_a = a.v && (!b.v || $signed(a.val) >= $signed(b.val));
  always_comb r_d = take_a ? a : b.v ? b : node_t'(SLOT_ZERO[NW-1:0]);
  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= '0;
    else if (i_en) r_q <= r_d;
  end
  assign o_v = r_q.v;
  assign o_val = r_q.val;
  assign o_idx = r_q.idx;
endmodule

// File: rtl/max_tree_seg.sv
// max_tree_seg: per-segment signed max/argmax over N_LANES lanes, all modes aligned to LAT cycles
module max_tree_seg
  import max_tree_pkg::*;
#(
  parameter int N_LANES = 64,
  parameter int DATA_W = 16,
  parameter int N_MODES = 3,
  localparam int LAT = clog2(N_LANES),
  localparam int MAX_SEGS = 1 << (N_MODES - 1),
  localparam int IDX_W = clog2(N_LANES),
  localparam int MW = (N_MODES > 1) ? clog2(N_MODES) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_in_valid,
  input  logic [MW-1:0]                i_length_mode,
  input  logic [N_LANES-1:0]           i_lane_valid,
  input  logic [N_LANES*DATA_W-1:0]    i_in_flat,
  output logic                         o_out_valid,
  output logic [MW-1:0]                o_length_mode,
  output logic [MAX_SEGS-1:0]          o_seg_valid,
  output logic [MAX_SEGS*DATA_W-1:0]   o_seg_max,
  output logic [MAX_SEGS*IDX_W-1:0]    o_seg_idx,
  output logic [N_LANES-1:0]           o_lane_valid_byp,
  output logic [N_LANES*DATA_W-1:0]    o_in_byp
);
  localparam int NW = 1 + DATA_W + IDX_W;
  localparam int SW = MAX_SEGS * NW;
  localparam int PW = 1 + MW + N_LANES + N_LANES * DATA_W;
  // Heap layout: node 1 is the root, node k has children 2k (lower lanes) and 2k+1,
  // leaves N_LANES..2*N_LANES-1 are the raw inputs. Depth d holds 2^d nodes in lane order.
  logic                     h_v   [1:2*N_LANES-1];
  logic signed [DATA_W-1:0] h_val [1:2*N_LANES-1];
  logic [IDX_W-1:0]         h_idx [1:2*N_LANES-1];
  logic [SW-1:0]            mode_slots [N_MODES];
  logic [SW-1:0]            slots;
  logic [PW-1:0]            side_d;
  logic [PW-1:0]            side_q [1:LAT];
  genvar j, k, m, t, s;
  for (j = 0; j < N_LANES; j++) begin : g_leaf
    assign h_v[N_LANES+j] = i_lane_valid[j];
    assign h_val[N_LANES+j] = i_in_flat[j*DATA_W +: DATA_W];
    assign h_idx[N_LANES+j] = IDX_W'(j);
  end
  for (k = 1; k < N_LANES; k++) begin : g_node
    max_idx_node #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_node (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
      .i_a_v(h_v[2*k]), .i_a_val(h_val[2*k]), .i_a_idx(h_idx[2*k]),
      .i_b_v(h_v[2*k+1]), .i_b_val(h_val[2*k+1]), .i_b_idx(h_idx[2*k+1]),
      .o_v(h_v[k]), .o_val(h_val[k]), .o_idx(h_idx[k])
    );
  end
  // Mode m taps depth m (2^m segments, ready after LAT-m cycles) and pads with m
  // registers so every mode leaves the block at exactly LAT.
  for (m = 0; m < N_MODES; m++) begin : g_mode
    localparam int NS = 1 << m;
    logic [NS*NW-1:0] tap;
    for (t = 0; t < NS; t++) begin : g_tap
      assign tap[t*NW +: NW] = {h_v[NS+t], h_val[NS+t], h_idx[NS+t]};
    end
    if (m == 0) begin : g_direct
      assign mode_slots[m] = SW'(tap);
    end else begin : g_delay
      logic [NS*NW-1:0] dly_q [1:m];
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 1; i <= m; i++) dly_q[i] <= '0;
        end else if (i_en) begin
          dly_q[1] <= tap;
          for (int i = 2; i <= m; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign mode_slots[m] = SW'(dly_q[m]);
    end
  end
  assign side_d = {i_in_valid, i_length_mode, i_lane_valid, i_in_flat};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 1; i <= LAT; i++) side_q[i] <= '0;
    end else if (i_en) begin
      side_q[1] <= side_d;
      for (int i = 2; i <= LAT; i++) side_q[i] <= side_q[i-1];
    end
  end
  assign {o_out_valid, o_length_mode, o_lane_valid_byp, o_in_byp} = side_q[LAT];
  // Slots beyond a mode's segment count are already zero from the width extension.
  always_comb slots = (int'(o_length_mode) < N_MODES) ? mode_slots[o_length_mode] : '0;
  for (s = 0; s < MAX_SEGS; s++) begin : g_out
    assign o_seg_valid[s] = slots[s*NW+NW-1];
    assign o_seg_max[s*DATA_W +: DATA_W] = slots[s*NW+IDX_W +: DATA_W];
    assign o_seg_idx[s*IDX_W +: IDX_W] = slots[s*NW +: IDX_W];
  end
endmodule

// File: tb/tb_max_tree_seg.sv
// tb_max_tree_seg: randomized and directed check of max_tree_seg against a lane-scan model
module tb_max_tree_seg;
  localparam int LAT = 6;
  logic i_clk = 0, i_rst = 1, i_en = 0, i_in_valid = 0;
  logic [1:0] i_length_mode = 0;
  logic [63:0] i_lane_valid = 0;
  logic [1023:0] i_in_flat = 0;
  logic o_out_valid;
  logic [1:0] o_length_mode;
  logic [3:0] o_seg_valid;
  logic [63:0] o_seg_max;
  logic [23:0] o_seg_idx;
  logic [63:0] o_lane_valid_byp;
  logic [1023:0] o_in_byp;
  int n_checks = 0, n_pass = 0;
  bit started = 0;
  typedef struct {
    logic v;
    logic [1:0] mode;
    logic [63:0] lv;
    logic [1023:0] flat;
  } beat_t;
  typedef struct {
    logic ov;
    logic [1:0] mode;
    logic [3:0] sv;
    logic [63:0] smax;
    logic [23:0] sidx;
    logic [63:0] lvb;
    logic [1023:0] byp;
  } exp_t;
  beat_t q[$];

  max_tree_seg dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_in_valid(i_in_valid),
    .i_length_mode(i_length_mode), .i_lane_valid(i_lane_valid), .i_in_flat(i_in_flat),
    .o_out_valid(o_out_valid), .o_length_mode(o_length_mode), .o_seg_valid(o_seg_valid),
    .o_seg_max(o_seg_max), .o_seg_idx(o_seg_idx), .o_lane_valid_byp(o_lane_valid_byp),
    .o_in_byp(o_in_byp)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    else n_pass++;
  endtask

  function automatic exp_t model(input beat_t b);
    exp_t e;
    int len;
    logic signed [15:0] best, val;
    int bi;
    bit found;
    e.ov = b.v; e.mode = b.mode; e.lvb = b.lv; e.byp = b.flat;
    e.sv = 0; e.smax = 0; e.sidx = 0;
    len = 64 >> b.mode;
    for (int sg = 0; sg < (1 << b.mode); sg++) begin
      found = 0; best = 0; bi = 0;
      for (int ln = sg * len; ln < (sg + 1) * len; ln++) begin
        val = b.flat[ln*16 +: 16];
        if (b.lv[ln] && (!found || val > best)) begin
          found = 1; best = val; bi = ln;
        end
      end
      e.sv[sg] = found;
      e.smax[sg*16 +: 16] = best;
      e.sidx[sg*6 +: 6] = 6'(bi);
    end
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.ov = 0; e.mode = 0; e.sv = 0; e.smax = 0; e.sidx = 0; e.lvb = 0; e.byp = 0;
    return e;
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      q.delete();
      started <= 1;
    end else if (i_en) begin
      q.push_back('{v: i_in_valid, mode: i_length_mode, lv: i_lane_valid, flat: i_in_flat});
      if (q.size() > LAT) void'(q.pop_front());
    end
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (started) begin
      e = (q.size() == LAT) ? model(q[0]) : zero_exp();
      chk("out_valid", 64'(o_out_valid), 64'(e.ov));
      chk("length_mode", 64'(o_length_mode), 64'(e.mode));
      chk("lane_valid_byp", o_lane_valid_byp, e.lvb);
      for (int c = 0; c < 16; c++) chk("in_byp", o_in_byp[c*64 +: 64], e.byp[c*64 +: 64]);
      if (e.ov || q.size() < LAT) begin
        chk("seg_valid", 64'(o_seg_valid), 64'(e.sv));
        chk("seg_max", o_seg_max, e.smax);
        chk("seg_idx", 64'(o_seg_idx), 64'(e.sidx));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send(input logic v, input logic [1:0] md);
    i_en = 1; i_in_valid = v; i_length_mode = md;
    cyc(1);
  endtask

  task automatic idle(input int n);
    i_en = 1; i_in_valid = 0;
    cyc(n);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int ln = 0; ln < 64; ln++) i_in_flat[ln*16 +: 16] = v;
  endtask

  initial begin
    cyc(2);
    i_rst = 0;
    chk("lit_reset_valid", 64'(o_out_valid), 64'd0);
    chk("lit_reset_max", o_seg_max, 64'd0);
    // mode 0, lane k = k-32, root gives 31 at lane 63
    i_lane_valid = '1;
    for (int ln = 0; ln < 64; ln++) i_in_flat[ln*16 +: 16] = 16'(ln - 32);
    send(1, 0);
    idle(LAT - 1);
    chk("lit_m0_valid", 64'(o_out_valid), 64'd1);
    chk("lit_m0_max", 64'(o_seg_max[15:0]), 64'd31);
    chk("lit_m0_idx", 64'(o_seg_idx[5:0]), 64'd63);
    chk("lit_m0_segv", 64'(o_seg_valid), 64'b0001);
    chk("lit_m0_hi_max", 64'(o_seg_max[63:16]), 64'd0);
    chk("lit_m0_hi_idx", 64'(o_seg_idx[23:6]), 64'd0);
    // mode 2, four peaks, must not appear at latency 4
    fill(16'hFFFF);
    i_in_flat[5*16 +: 16] = 16'h7000; i_in_flat[20*16 +: 16] = 16'h7000;
    i_in_flat[40*16 +: 16] = 16'h7000; i_in_flat[60*16 +: 16] = 16'h7000;
    send(1, 2);
    idle(3);
    chk("lit_m2_not_at_4", 64'(o_out_valid), 64'd0);
    idle(2);
    chk("lit_m2_valid", 64'(o_out_valid), 64'd1);
    chk("lit_m2_max", o_seg_max, 64'h7000_7000_7000_7000);
    chk("lit_m2_idx", 64'(o_seg_idx), 64'({6'd60, 6'd40, 6'd20, 6'd5}));
    chk("lit_m2_segv", 64'(o_seg_valid), 64'b1111);
    // mode 1, lower half masked
    fill(16'hFFFB);
    i_in_flat[0 +: 16] = 16'h7FFF; i_in_flat[45*16 +: 16] = 16'd100;
    i_lane_valid = {32'hFFFF_FFFF, 32'h0};
    send(1, 1);
    idle(LAT - 1);
    chk("lit_m1_segv", 64'(o_seg_valid), 64'b0010);
    chk("lit_m1_max", o_seg_max, 64'h0000_0000_0064_0000);
    chk("lit_m1_idx", 64'(o_seg_idx), 64'({6'd0, 6'd0, 6'd45, 6'd0}));
    // ties
    i_lane_valid = '1;
    fill(16'hFFF9);
    send(1, 0);
    fill(16'hFFFF);
    i_in_flat[3*16 +: 16] = 16'd50; i_in_flat[9*16 +: 16] = 16'd50;
    send(1, 2);
    idle(LAT - 2);
    chk("lit_tie_m0_max", 64'(o_seg_max[15:0]), 64'hFFF9);
    chk("lit_tie_m0_idx", 64'(o_seg_idx[5:0]), 64'd0);
    idle(1);
    chk("lit_tie_m2_idx", 64'(o_seg_idx[5:0]), 64'd3);
    chk("lit_tie_m2_max", 64'(o_seg_max[15:0]), 64'd50);
    // back-to-back modes with a mid-stream stall
    for (int b = 0; b < 4; b++) begin
      for (int ln = 0; ln < 64; ln++) i_in_flat[ln*16 +: 16] = 16'($urandom);
      i_lane_valid = {$urandom, $urandom};
      send(1, (b == 3) ? 2'd0 : 2'(b));
      if (b == 1) begin
        i_en = 0;
        cyc(3);
      end
    end
    idle(LAT + 1);
    // reset with beats in flight
    repeat (3) send(1, 2'($urandom_range(0, 2)));
    i_rst = 1;
    cyc(1);
    i_rst = 0;
    chk("lit_rst_valid", 64'(o_out_valid), 64'd0);
    chk("lit_rst_segv", 64'(o_seg_valid), 64'd0);
    chk("lit_rst_byp", o_in_byp[63:0], 64'd0);
    send(1, 0);
    idle(LAT - 2);
    chk("lit_rst_still_low", 64'(o_out_valid), 64'd0);
    idle(1);
    chk("lit_rst_first_out", 64'(o_out_valid), 64'd1);
    // randomized traffic
    for (int it = 0; it < 600; it++) begin
      i_rst = ($urandom_range(0, 149) == 0);
      i_en = ($urandom_range(0, 9) != 0);
      i_in_valid = ($urandom_range(0, 3) != 0);
      i_length_mode = 2'($urandom_range(0, 2));
      i_lane_valid = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
      for (int ln = 0; ln < 64; ln++)
        i_in_flat[ln*16 +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 6) - 3) : 16'($urandom);
      cyc(1);
    end
    i_rst = 0;
    idle(LAT + 2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
